// File: rtl/stg_idex_pkg.sv
// Shared types for the ID->EX stage: field widths, FSM encoding, EX payload and bubble value.
package stg_idex_pkg;

    localparam int unsigned OPC_W = 8;
    localparam int unsigned GP_W  = 4;
    localparam int unsigned SR_W  = 2;
    localparam int unsigned IMM_W = 24;
    localparam int unsigned PC_W  = 24;

    localparam logic [OPC_W-1:0] OPC_NOP = 8'h00;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [PC_W-1:0]  pc;
        logic [OPC_W-1:0] opc;
        logic [GP_W-1:0]  tgt_gp;
        logic             tgt_gp_we;
        logic [GP_W-1:0]  src_gp;
        logic [SR_W-1:0]  tgt_sr;
        logic             tgt_sr_we;
        logic [SR_W-1:0]  src_sr;
        logic [IMM_W-1:0] imm;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{
        valid:     1'b0,
        pc:        '0,
        opc:       OPC_NOP,
        tgt_gp:    '0,
        tgt_gp_we: 1'b0,
        src_gp:    '0,
        tgt_sr:    '0,
        tgt_sr_we: 1'b0,
        src_sr:    '0,
        imm:       '0
    };

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stg_idex.sv
// ID->EX pipeline register with stall bubbles, flush-driven squash window and perf counters.
module stg_idex
    import stg_idex_pkg::*;
#(
    parameter int unsigned SQ_LEN = 2,   // ID slots killed per flush, flush cycle included (1..3)
    parameter int unsigned CNT_W  = 16
) (
    input  logic             iw_clk,
    input  logic             iw_rst_n,
    input  logic             iw_stall,
    input  logic             iw_flush,
    input  logic             iw_valid,
    input  logic [PC_W-1:0]  iw_pc,
    input  logic [OPC_W-1:0] iw_opc,
    input  logic [GP_W-1:0]  iw_tgt_gp,
    input  logic             iw_tgt_gp_we,
    input  logic [GP_W-1:0]  iw_src_gp,
    input  logic [SR_W-1:0]  iw_tgt_sr,
    input  logic             iw_tgt_sr_we,
    input  logic [SR_W-1:0]  iw_src_sr,
    input  logic [IMM_W-1:0] iw_imm,
    output logic             ow_valid,
    output logic [PC_W-1:0]  ow_pc,
    output logic [OPC_W-1:0] ow_opc,
    output logic [GP_W-1:0]  ow_tgt_gp,
    output logic             ow_tgt_gp_we,
    output logic [GP_W-1:0]  ow_src_gp,
    output logic [SR_W-1:0]  ow_tgt_sr,
    output logic             ow_tgt_sr_we,
    output logic [SR_W-1:0]  ow_src_sr,
    output logic [IMM_W-1:0] ow_imm,
    output logic             ow_ifid_hold,
    output logic [CNT_W-1:0] ow_stall_cnt,
    output logic [CNT_W-1:0] ow_squash_cnt
);

    localparam int unsigned      SQ_CNT_W  = 2;
    localparam logic [SQ_CNT_W-1:0] SQ_RELOAD = SQ_CNT_W'(SQ_LEN - 1);

    state_e              state_q, state_d;
    logic [SQ_CNT_W-1:0] sq_cnt_q, sq_cnt_d;
    idex_t               ex_q, ex_d;
    idex_t               id_fields;
    logic                stall_inc;
    logic                squash_inc;

    assign id_fields = '{
        valid:     iw_valid,
        pc:        iw_pc,
        opc:       iw_opc,
        tgt_gp:    iw_tgt_gp,
        tgt_gp_we: iw_tgt_gp_we,
        src_gp:    iw_src_gp,
        tgt_sr:    iw_tgt_sr,
        tgt_sr_we: iw_tgt_sr_we,
        src_sr:    iw_src_sr,
        imm:       iw_imm
    };

    // Flush outranks the squash window, which outranks stall; stall is ignored while squashing.
    always_comb begin
        state_d    = state_q;
        sq_cnt_d   = sq_cnt_q;
        ex_d       = IDEX_BUBBLE;
        stall_inc  = 1'b0;
        squash_inc = 1'b0;

        if (iw_flush) begin
            squash_inc = iw_valid;
            sq_cnt_d   = SQ_RELOAD;
            state_d    = (SQ_LEN > 1) ? ST_SQUASH : ST_RUN;
        end else begin
            unique case (state_q)
                ST_SQUASH: begin
                    squash_inc = iw_valid;
                    sq_cnt_d   = sq_cnt_q - SQ_CNT_W'(1);
                    if (sq_cnt_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (iw_stall) begin
                        stall_inc = 1'b1;
                        state_d   = ST_STALL;
                    end else begin
                        state_d = ST_RUN;
                        if (iw_valid) begin
                            ex_d = id_fields;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q  <= ST_RUN;
            sq_cnt_q <= '0;
            ex_q     <= IDEX_BUBBLE;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
            ex_q     <= ex_d;
        end
    end

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (iw_clk),
        .rst_n (iw_rst_n),
        .inc   (stall_inc),
        .count (ow_stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_squash_cnt (
        .clk   (iw_clk),
        .rst_n (iw_rst_n),
        .inc   (squash_inc),
        .count (ow_squash_cnt)
    );

    assign ow_ifid_hold = iw_stall & ~iw_flush;

    assign ow_valid     = ex_q.valid;
    assign ow_pc        = ex_q.pc;
    assign ow_opc       = ex_q.opc;
    assign ow_tgt_gp    = ex_q.tgt_gp;
    assign ow_tgt_gp_we = ex_q.tgt_gp_we;
    assign ow_src_gp    = ex_q.src_gp;
    assign ow_tgt_sr    = ex_q.tgt_sr;
    assign ow_tgt_sr_we = ex_q.tgt_sr_we;
    assign ow_src_sr    = ex_q.src_sr;
    assign ow_imm       = ex_q.imm;

endmodule

// File: tb/tb_stg_idex.sv
// Bench for stg_idex: cycle model of the squash/stall/load rules plus directed literal checks.
module tb_stg_idex;

    localparam int SQ_LEN  = 2;
    localparam int CNT_MAX = 65535;
    localparam logic [7:0] NOP = 8'h00;

    logic        iw_clk = 1'b0;
    logic        iw_rst_n;
    logic        iw_stall, iw_flush, iw_valid;
    logic [23:0] iw_pc;
    logic [7:0]  iw_opc;
    logic [3:0]  iw_tgt_gp, iw_src_gp;
    logic        iw_tgt_gp_we, iw_tgt_sr_we;
    logic [1:0]  iw_tgt_sr, iw_src_sr;
    logic [23:0] iw_imm;
    logic        ow_valid;
    logic [23:0] ow_pc;
    logic [7:0]  ow_opc;
    logic [3:0]  ow_tgt_gp, ow_src_gp;
    logic        ow_tgt_gp_we, ow_tgt_sr_we;
    logic [1:0]  ow_tgt_sr, ow_src_sr;
    logic [23:0] ow_imm;
    logic        ow_ifid_hold;
    logic [15:0] ow_stall_cnt, ow_squash_cnt;

    int vectors = 0;
    int errors  = 0;

    stg_idex #(.SQ_LEN(SQ_LEN), .CNT_W(16)) dut (
        .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_stall(iw_stall), .iw_flush(iw_flush),
        .iw_valid(iw_valid), .iw_pc(iw_pc), .iw_opc(iw_opc), .iw_tgt_gp(iw_tgt_gp),
        .iw_tgt_gp_we(iw_tgt_gp_we), .iw_src_gp(iw_src_gp), .iw_tgt_sr(iw_tgt_sr),
        .iw_tgt_sr_we(iw_tgt_sr_we), .iw_src_sr(iw_src_sr), .iw_imm(iw_imm),
        .ow_valid(ow_valid), .ow_pc(ow_pc), .ow_opc(ow_opc), .ow_tgt_gp(ow_tgt_gp),
        .ow_tgt_gp_we(ow_tgt_gp_we), .ow_src_gp(ow_src_gp), .ow_tgt_sr(ow_tgt_sr),
        .ow_tgt_sr_we(ow_tgt_sr_we), .ow_src_sr(ow_src_sr), .ow_imm(ow_imm),
        .ow_ifid_hold(ow_ifid_hold), .ow_stall_cnt(ow_stall_cnt), .ow_squash_cnt(ow_squash_cnt)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining squash slots, expected EX payload and counter values.
    int          m_sq_left;
    int          m_stall_cnt;
    int          m_squash_cnt;
    logic [70:0] m_ex;
    logic [70:0] bubble;
    logic [70:0] dut_ex;

    assign bubble = {1'b0, 24'h0, NOP, 4'h0, 1'b0, 4'h0, 2'h0, 1'b0, 2'h0, 24'h0};
    assign dut_ex = {ow_valid, ow_pc, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_src_gp,
                     ow_tgt_sr, ow_tgt_sr_we, ow_src_sr, ow_imm};

    always @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            m_sq_left = 0; m_stall_cnt = 0; m_squash_cnt = 0; m_ex = bubble;
        end else if (iw_flush) begin
            m_ex = bubble;
            m_sq_left = SQ_LEN - 1;
            if (iw_valid && m_squash_cnt < CNT_MAX) m_squash_cnt++;
        end else if (m_sq_left > 0) begin
            m_ex = bubble;
            m_sq_left--;
            if (iw_valid && m_squash_cnt < CNT_MAX) m_squash_cnt++;
        end else if (iw_stall) begin
            m_ex = bubble;
            if (m_stall_cnt < CNT_MAX) m_stall_cnt++;
        end else begin
            m_ex = iw_valid ? {1'b1, iw_pc, iw_opc, iw_tgt_gp, iw_tgt_gp_we, iw_src_gp,
                               iw_tgt_sr, iw_tgt_sr_we, iw_src_sr, iw_imm} : bubble;
        end
        #1;
        check("ex_fields", 128'(dut_ex), 128'(m_ex));
        check("stall_cnt", 128'(ow_stall_cnt), 128'(m_stall_cnt));
        check("squash_cnt", 128'(ow_squash_cnt), 128'(m_squash_cnt));
        check("ifid_hold", 128'(ow_ifid_hold), 128'(iw_stall & ~iw_flush));
    end

    task automatic drive(input logic st, input logic fl, input logic v, input logic [7:0] opc);
        iw_stall = st; iw_flush = fl; iw_valid = v; iw_opc = opc;
        iw_pc = 24'($urandom); iw_imm = 24'($urandom);
        iw_tgt_gp = 4'($urandom); iw_src_gp = 4'($urandom);
        iw_tgt_sr = 2'($urandom); iw_src_sr = 2'($urandom);
        iw_tgt_gp_we = 1'($urandom); iw_tgt_sr_we = 1'($urandom);
    endtask

    task automatic tick();
        @(negedge iw_clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iw_rst_n = 1'b0;
        drive(0, 0, 0, 8'h00);
        repeat (2) tick();
        check("rst_valid", 128'(ow_valid), 128'(0));
        check("rst_opc", 128'(ow_opc), 128'(NOP));
        check("rst_pc", 128'(ow_pc), 128'(0));
        check("rst_stall_cnt", 128'(ow_stall_cnt), 128'(0));
        check("rst_squash_cnt", 128'(ow_squash_cnt), 128'(0));
        iw_rst_n = 1'b1;

        // Reset asserted while the squash window is open.
        drive(0, 1, 1, 8'h60); tick();
        check("t1_sq_before_rst", 128'(ow_squash_cnt), 128'(1));
        drive(0, 0, 1, 8'h61);
        #2 iw_rst_n = 1'b0;
        #1;
        check("t1_rst_valid", 128'(ow_valid), 128'(0));
        check("t1_rst_opc", 128'(ow_opc), 128'(NOP));
        check("t1_rst_squash", 128'(ow_squash_cnt), 128'(0));
        check("t1_rst_imm", 128'(ow_imm), 128'(0));
        tick(); tick();
        iw_rst_n = 1'b1;
        drive(0, 0, 1, 8'h55); tick();
        check("t1_run_after_rst", 128'({ow_valid, ow_opc}), 128'({1'b1, 8'h55}));

        // Back-to-back stream.
        drive(0, 0, 1, 8'h12); #1 check("t2_hold", 128'(ow_ifid_hold), 128'(0));
        tick(); check("t2_opc12", 128'(ow_opc), 128'(8'h12));
        drive(0, 0, 1, 8'h13); tick(); check("t2_opc13", 128'(ow_opc), 128'(8'h13));
        drive(0, 0, 1, 8'h14); tick(); check("t2_opc14", 128'(ow_opc), 128'(8'h14));

        // Three-cycle stall with 0x21 held in ID.
        drive(1, 0, 1, 8'h21); #1 check("t3_hold", 128'(ow_ifid_hold), 128'(1));
        for (int i = 0; i < 3; i++) begin
            tick(); check("t3_bubble", 128'(ow_valid), 128'(0));
        end
        iw_stall = 1'b0; tick();
        check("t3_opc21", 128'({ow_valid, ow_opc}), 128'({1'b1, 8'h21}));
        check("t3_stall_cnt", 128'(ow_stall_cnt), 128'(3));
        drive(0, 0, 0, 8'h00); tick();
        check("t3_once", 128'(ow_valid), 128'(0));

        // Flush in RUN: two bubbles, then the next instruction loads.
        drive(0, 1, 1, 8'h40); tick(); check("t4_b1", 128'(ow_valid), 128'(0));
        drive(0, 0, 1, 8'h41); tick(); check("t4_b2", 128'(ow_valid), 128'(0));
        drive(0, 0, 1, 8'h42); tick();
        check("t4_load", 128'({ow_valid, ow_opc}), 128'({1'b1, 8'h42}));
        check("t4_squash_cnt", 128'(ow_squash_cnt), 128'(2));

        // Flush with stall, then re-flush inside the window.
        drive(1, 1, 1, 8'h50); #1 check("t5_hold", 128'(ow_ifid_hold), 128'(0));
        tick(); check("t5_b1", 128'(ow_valid), 128'(0));
        check("t5_no_stall", 128'(ow_stall_cnt), 128'(3));
        drive(0, 1, 1, 8'h51); tick(); check("t5_b2", 128'(ow_valid), 128'(0));
        drive(0, 0, 1, 8'h52); tick(); check("t5_b3", 128'(ow_valid), 128'(0));
        drive(0, 0, 1, 8'h53); tick();
        check("t5_load", 128'({ow_valid, ow_opc}), 128'({1'b1, 8'h53}));
        check("t5_squash_cnt", 128'(ow_squash_cnt), 128'(5));
        check("t5_stall_cnt", 128'(ow_stall_cnt), 128'(3));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 9) < 7), 8'($urandom));
            tick();
        end

        // Long stall drives the stall counter into saturation.
        drive(1, 0, 1, 8'h77);
        for (int i = 0; i < 65540; i++) tick();
        check("t6_saturate", 128'(ow_stall_cnt), 128'(16'hFFFF));
        drive(0, 0, 1, 8'h78); tick();
        check("t6_hold_sat", 128'(ow_stall_cnt), 128'(16'hFFFF));
        check("t6_load", 128'({ow_valid, ow_opc}), 128'({1'b1, 8'h78}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
